// File: rtl/spi_pkg.sv
// spi_pkg: shared state encodings and parameter defaults
// for the multi-slave SPI master and its clock generator.
package spi_pkg;

  localparam int D_WIDTH_DEF = 8;
  localparam int SLAVES_DEF  = 4;
  localparam int DIV_W_DEF   = 16;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period divider and edge sequencer.
// Emits launch/capture strobes aligned to each sclk toggle.
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             launch,
  output logic             capture,
  output logic             last_cap,
  output logic             frame_end
);

  localparam int EW = $clog2(2 * D_WIDTH);
  localparam logic [EW-1:0] LAST   = EW'(2 * D_WIDTH - 1);
  localparam logic [EW-1:0] PENULT = EW'(2 * D_WIDTH - 2);

  logic [DIV_W-1:0] cnt;
  logic [EW-1:0]    ecnt;
  logic             lead;

  // Odd-numbered toggles are leading edges; cpha picks which edge captures.
  always_comb begin
    tick      = run && (cnt == div - DIV_W'(1));
    lead      = ~ecnt[0];
    capture   = tick && (lead ^ cpha);
    launch    = tick && !(lead ^ cpha);
    last_cap  = capture && (ecnt == (cpha ? LAST : PENULT));
    frame_end = tick && (ecnt == LAST);
  end

  // Half-period counter and per-frame toggle index, wrapping every frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      ecnt <= '0;
    end else if (!run) begin
      cnt  <= '0;
      ecnt <= '0;
    end else if (tick) begin
      cnt  <= '0;
      ecnt <= (ecnt == LAST) ? '0 : ecnt + EW'(1);
    end else begin
      cnt  <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with per-slave chip selects,
// all four clock modes and back-to-back continuous frames.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF,
  parameter int SLAVES  = SLAVES_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic                       cont,
  input  logic [addr_w(SLAVES)-1:0]  addr,
  input  logic [DIV_W-1:0]           clk_div,
  input  logic [D_WIDTH-1:0]         tx_data,
  input  logic                       miso,
  output logic                       sclk,
  output logic [SLAVES-1:0]          ss_n,
  output logic                       mosi,
  output logic                       busy,
  output logic                       tx_load,
  output logic                       rx_valid,
  output logic [D_WIDTH-1:0]         rx_data
);

  logic [0:0]         state;
  logic               tail;
  logic               cpha_q;
  logic [DIV_W-1:0]   div_q;
  logic [D_WIDTH-1:0] tx_sh;
  logic [D_WIDTH-1:0] rx_sh;
  logic               tick;
  logic               launch;
  logic               capture;
  logic               last_cap;
  logic               frame_end;

  spi_clkgen #(
    .D_WIDTH (D_WIDTH),
    .DIV_W   (DIV_W)
  ) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state == S_EXEC),
    .cpha      (cpha_q),
    .div       (div_q),
    .tick      (tick),
    .launch    (launch),
    .capture   (capture),
    .last_cap  (last_cap),
    .frame_end (frame_end)
  );

  // Transaction sequencer: accept, shift, chain or release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tail     <= 1'b0;
      busy     <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b1;
      ss_n     <= '1;
      tx_load  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      cpha_q   <= 1'b0;
      div_q    <= DIV_W'(1);
    end else begin
      tx_load  <= 1'b0;
      rx_valid <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          busy <= enable;
          if (enable) begin
            state   <= S_EXEC;
            tail    <= 1'b0;
            cpha_q  <= cpha;
            div_q   <= (clk_div == '0) ? DIV_W'(1) : clk_div;
            sclk    <= cpol;
            ss_n    <= ~(SLAVES'(1) << addr);
            tx_load <= 1'b1;
            rx_sh   <= '0;
            if (cpha) begin
              mosi  <= 1'b1;
              tx_sh <= tx_data;
            end else begin
              mosi  <= tx_data[D_WIDTH-1];
              tx_sh <= {tx_data[D_WIDTH-2:0], 1'b0};
            end
          end
        end
        (state == S_EXEC): begin
          if (tail) begin
            if (tick) begin
              state <= S_IDLE;
              tail  <= 1'b0;
              busy  <= 1'b0;
            end
          end else begin
            if (tick) sclk <= ~sclk;
            if (capture) begin
              rx_sh <= {rx_sh[D_WIDTH-2:0], miso};
              if (last_cap) begin
                rx_data  <= {rx_sh[D_WIDTH-2:0], miso};
                rx_valid <= 1'b1;
              end
            end
            if (launch && !frame_end) begin
              mosi  <= tx_sh[D_WIDTH-1];
              tx_sh <= {tx_sh[D_WIDTH-2:0], 1'b0};
            end
            if (frame_end) begin
              if (cont) begin
                tx_load <= 1'b1;
                if (cpha_q) begin
                  tx_sh <= tx_data;
                end else begin
                  mosi  <= tx_data[D_WIDTH-1];
                  tx_sh <= {tx_data[D_WIDTH-2:0], 1'b0};
                end
              end else begin
                tail <= 1'b1;
                mosi <= 1'b1;
                ss_n <= '1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: directed and random transactions checked
// against a behavioural SPI slave and frame-level expectations.
module tb_spi_master_multi;

  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        cont = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] clk_div = 16'd1;
  logic [7:0]  tx_data = 8'd0;
  logic        miso;
  logic        s_miso = 1'b1;
  bit          loopback = 1'b0;
  logic        sclk, mosi, busy, tx_load, rx_valid;
  logic [3:0]  ss_n;
  logic [7:0]  rx_data;

  int n_assert = 0;
  int n_fail = 0;

  assign miso = loopback ? mosi : s_miso;

  spi_master_multi #(
    .D_WIDTH (8),
    .SLAVES  (4),
    .DIV_W   (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .cpol     (cpol),
    .cpha     (cpha),
    .cont     (cont),
    .addr     (addr),
    .clk_div  (clk_div),
    .tx_data  (tx_data),
    .miso     (miso),
    .sclk     (sclk),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .busy     (busy),
    .tx_load  (tx_load),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  always #5 clk = ~clk;

  // expectations and observations for the current transaction
  logic [3:0] exp_ss = 4'hF;
  int         exp_half = 1;
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  logic [7:0] m_words [4];
  logic [7:0] s_words [4];
  logic [7:0] rxq [$];
  logic [7:0] s_got [$];
  int toggles = 0, hp_bad = 0, ss_bad = 0, ss_rises = 0, loads = 0, cyc = 0;

  // slave state
  logic [7:0] s_sh = 8'd0;
  logic [7:0] s_rx = 8'd0;
  int         cap = 0;
  int         s_fidx = 0;
  bit         need_load = 1'b0;
  logic [3:0] prev_ss = 4'hF;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_load();
    if (s_fidx < 4) s_sh = s_words[s_fidx];
    s_fidx++;
  endtask

  task automatic slave_start();
    s_fidx = 0;
    cap = 0;
    s_rx = 8'd0;
    cyc = 0;
    need_load = 1'b1;
    if (!s_cpha) begin
      slave_load();
      need_load = 1'b0;
      s_miso = s_sh[7];
      s_sh = {s_sh[6:0], 1'b0};
    end
  endtask

  task automatic slave_launch();
    if (need_load) begin
      slave_load();
      need_load = 1'b0;
    end
    s_miso = s_sh[7];
    s_sh = {s_sh[6:0], 1'b0};
  endtask

  task automatic slave_capture();
    s_rx = {s_rx[6:0], prev_mosi};
    cap++;
    if (cap == DW) begin
      s_got.push_back(s_rx);
      cap = 0;
      need_load = 1'b1;
    end
  endtask

  // Bus monitor and mode-matched slave, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ss = ss_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end else begin
      cyc++;
      if (tx_load) loads++;
      if (rx_valid) rxq.push_back(rx_data);
      if (!(&ss_n) && (ss_n !== exp_ss)) ss_bad++;
      if ((&ss_n) && !(&prev_ss)) ss_rises++;
      if (!(&ss_n) && (&prev_ss)) begin
        slave_start();
      end else if (!(&prev_ss) && (sclk !== prev_sclk)) begin
        toggles++;
        if (cyc != exp_half) hp_bad++;
        cyc = 0;
        if (((sclk != s_cpol) ^ s_cpha) == 1'b1) slave_capture();
        else if (!(&ss_n)) slave_launch();
      end
      prev_ss = ss_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  end

  task automatic clear_mon();
    toggles = 0;
    hp_bad = 0;
    ss_bad = 0;
    ss_rises = 0;
    loads = 0;
    rxq.delete();
    s_got.delete();
  endtask

  task automatic run_txn(input logic [1:0] a, input logic pol,
                         input logic pha, input logic [15:0] dv,
                         input int n, input bit perturb);
    bit got;
    clear_mon();
    exp_ss = ~(4'b0001 << a);
    exp_half = (dv == 16'd0) ? 1 : int'(dv);
    s_cpol = pol;
    s_cpha = pha;
    addr = a;
    cpol = pol;
    cpha = pha;
    clk_div = dv;
    tx_data = m_words[0];
    cont = (n > 1);
    enable = 1'b1;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int c = 0; c < 400 && !got; c++) begin
        @(posedge clk);
        #1;
        got = tx_load;
      end
      chk("tx_load_seen", {31'd0, got}, 32'd1);
      if (k == 0) begin
        enable = 1'b0;
        if (perturb) begin
          addr = ~a;
          clk_div = dv + 16'd3;
          cpha = ~pha;
          cpol = ~pol;
          enable = 1'b1;
          @(posedge clk);
          #1;
          enable = 1'b0;
        end
      end
      if (k + 1 < 4) tx_data = m_words[k+1];
      cont = (k + 1 < n);
    end
    for (int c = 0; c < 1000 && busy; c++) begin
      @(posedge clk);
      #1;
    end
    chk("busy_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
    chk("toggles", toggles, 2 * DW * n);
    chk("half_period_bad", hp_bad, 0);
    chk("ss_pattern_bad", ss_bad, 0);
    chk("ss_rises", ss_rises, 1);
    chk("tx_loads", loads, n);
    chk("rx_count", rxq.size(), n);
    chk("slave_count", s_got.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < rxq.size())
        chk("rx_data", {24'd0, rxq[k]},
            {24'd0, loopback ? m_words[k] : s_words[k]});
      if (k < s_got.size())
        chk("slave_rx", {24'd0, s_got[k]}, {24'd0, m_words[k]});
    end
    chk("idle_mosi", {31'd0, mosi}, 32'd1);
    chk("idle_ss", {28'd0, ss_n}, 32'hF);
    chk("idle_sclk", {31'd0, sclk}, {31'd0, pol});
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #5;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ss", {28'd0, ss_n}, 32'hF);
    chk("rst_mosi", {31'd0, mosi}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_tx_load", {31'd0, tx_load}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    #16 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_rst", {31'd0, busy}, 32'd0);

    // loopback, mode 0, slave 2
    m_words[0] = 8'hA5;
    s_words[0] = 8'h00;
    loopback = 1'b1;
    run_txn(2'd2, 1'b0, 1'b0, 16'd2, 1, 1'b0);
    loopback = 1'b0;

    // all four clock modes
    for (int m = 0; m < 4; m++) begin
      m_words[0] = 8'h3C;
      s_words[0] = 8'hC3;
      run_txn(2'(m), m[1], m[0], 16'(1 + m % 3), 1, 1'b0);
    end

    // continuous three-frame burst
    m_words[0] = 8'h11;
    m_words[1] = 8'h22;
    m_words[2] = 8'h33;
    s_words[0] = 8'h9A;
    s_words[1] = 8'hBC;
    s_words[2] = 8'hDE;
    run_txn(2'd1, 1'b0, 1'b0, 16'd2, 3, 1'b0);
    run_txn(2'd0, 1'b1, 1'b1, 16'd1, 3, 1'b0);

    // zero divider behaves as one
    m_words[0] = 8'h96;
    s_words[0] = 8'h4B;
    run_txn(2'd3, 1'b0, 1'b1, 16'd0, 1, 1'b0);

    // mid-frame input changes ignored, then applied on next enable
    m_words[0] = 8'hE1;
    s_words[0] = 8'h1E;
    run_txn(2'd0, 1'b1, 1'b0, 16'd3, 1, 1'b1);
    m_words[0] = 8'h7F;
    s_words[0] = 8'h80;
    run_txn(2'd3, 1'b0, 1'b1, 16'd6, 1, 1'b0);

    // reset asserted mid-frame
    clear_mon();
    exp_ss = 4'b1101;
    exp_half = 2;
    s_cpol = 1'b0;
    s_cpha = 1'b0;
    m_words[0] = 8'h5A;
    s_words[0] = 8'hC6;
    addr = 2'd1;
    cpol = 1'b0;
    cpha = 1'b0;
    clk_div = 16'd2;
    tx_data = 8'h5A;
    cont = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    for (int c = 0; c < 200 && toggles < 7; c++) begin
      @(negedge clk);
      #1;
    end
    chk("toggle7_reached", toggles, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_ss", {28'd0, ss_n}, 32'hF);
    chk("abort_mosi", {31'd0, mosi}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    chk("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy_clear", {31'd0, busy}, 32'd0);
    chk("abort_no_rx", rxq.size(), 0);
    run_txn(2'd1, 1'b0, 1'b0, 16'd2, 1, 1'b0);

    // randomized transactions
    for (int r = 0; r < 6; r++) begin
      int n;
      logic [1:0] a;
      logic pl, ph;
      logic [15:0] dv;
      n = $urandom_range(1, 3);
      a = 2'($urandom_range(0, 3));
      pl = 1'($urandom_range(0, 1));
      ph = 1'($urandom_range(0, 1));
      dv = 16'($urandom_range(0, 4));
      for (int k = 0; k < 4; k++) begin
        m_words[k] = 8'($urandom);
        s_words[k] = 8'($urandom);
      end
      run_txn(a, pl, ph, dv, n, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
